// File: rtl/decode_stage_hazard_if.sv
// -----------------------------------------------------------------------------
// decode_stage_hazard_if
//   Bundles every signal of the decode stage except clk/resetN.
//   Signal groups:
//     - fetch side:     inValid, instruction, programCounterIn, flush, inReady
//     - writeback side: regWrite, writeRegister, writeData
//     - execute side:   outValid, writeBackControl, memAccessControl,
//                       calculationControl, programCounterOut, readData1,
//                       readData2, immediateOperand, writeRegister0,
//                       writeRegister1
//     - status:         stallCount
//   Modports:
//     - slave:  the decode stage itself.
//     - master: whoever drives fetch and writeback and observes execute.
//   The parameters must match the ones given to decode_stage_hazard.
// -----------------------------------------------------------------------------
interface decode_stage_hazard_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int STALL_CNT_WIDTH = 16
);
    // fetch side
    logic                       inValid;
    logic [31:0]                instruction;
    logic [DATA_WIDTH-1:0]      programCounterIn;
    logic                       flush;
    logic                       inReady;

    // writeback side
    logic                       regWrite;
    logic [REG_ADDR_WIDTH-1:0]  writeRegister;
    logic [DATA_WIDTH-1:0]      writeData;

    // execute side
    logic                       outValid;
    logic [1:0]                 writeBackControl;
    logic [2:0]                 memAccessControl;
    logic [3:0]                 calculationControl;
    logic [DATA_WIDTH-1:0]      programCounterOut;
    logic [DATA_WIDTH-1:0]      readData1;
    logic [DATA_WIDTH-1:0]      readData2;
    logic [DATA_WIDTH-1:0]      immediateOperand;
    logic [REG_ADDR_WIDTH-1:0]  writeRegister0;
    logic [REG_ADDR_WIDTH-1:0]  writeRegister1;

    // status
    logic [STALL_CNT_WIDTH-1:0] stallCount;

    modport slave (
        input  inValid, instruction, programCounterIn, flush,
        input  regWrite, writeRegister, writeData,
        output inReady,
        output outValid, writeBackControl, memAccessControl, calculationControl,
        output programCounterOut, readData1, readData2, immediateOperand,
        output writeRegister0, writeRegister1, stallCount
    );

    modport master (
        output inValid, instruction, programCounterIn, flush,
        output regWrite, writeRegister, writeData,
        input  inReady,
        input  outValid, writeBackControl, memAccessControl, calculationControl,
        input  programCounterOut, readData1, readData2, immediateOperand,
        input  writeRegister0, writeRegister1, stallCount
    );
endinterface

// File: rtl/decode_stage_hazard.sv
// -----------------------------------------------------------------------------
// decode_stage_hazard
//   Instruction-decode pipeline stage between fetch and execute.
//   It does the following:
//     - Holds the register file.
//     - Decodes the opcode into writeback, memory and ALU control fields.
//     - Sign-extends the 16-bit immediate.
//     - Forwards a same-cycle writeback onto the operands.
//     - Detects a load-use hazard, holds fetch for one cycle and sends a bubble.
//     - Supports flush.
//     - Counts hazard stall cycles in a saturating counter.
//
// Ports
//   clk     rising-edge clock
//   resetN  asynchronous active-low reset
//   bus     decode_stage_hazard_if.slave, carrying these signals:
//     - fetch in:      inValid, instruction, programCounterIn, flush
//     - fetch out:     inReady (combinational)
//     - writeback in:  regWrite, writeRegister, writeData
//     - execute out (all registered): outValid, writeBackControl,
//       memAccessControl, calculationControl, programCounterOut, readData1,
//       readData2, immediateOperand, writeRegister0 (rt), writeRegister1 (rd)
//     - stallCount     number of hazard stall cycles since reset
//
// Control encoding
//   writeBackControl   = {regWrite, memToReg}
//   memAccessControl   = memRead at MEM_READ_BIT; memWrite and branch fill the
//                        next two bit positions, wrapping round the 3-bit field
//   calculationControl = {regDst, aluOp[1:0], aluSrc}
// -----------------------------------------------------------------------------
module decode_stage_hazard #(
    parameter int DATA_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int MEM_READ_BIT    = 0,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetN,
    decode_stage_hazard_if.slave bus
);
    localparam int DW    = DATA_WIDTH;
    localparam int RA    = REG_ADDR_WIDTH;
    localparam int SW    = STALL_CNT_WIDTH;
    localparam int DEPTH = 2 ** RA;

    localparam int MEM_WRITE_BIT  = (MEM_READ_BIT + 1) % 3;
    localparam int MEM_BRANCH_BIT = (MEM_READ_BIT + 2) % 3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]    opcode;
    logic [RA-1:0] rs_idx;
    logic [RA-1:0] rt_idx;
    logic [RA-1:0] rd_idx;
    logic [DW-1:0] imm_ext;

    assign opcode  = bus.instruction[31:26];
    assign rs_idx  = bus.instruction[21 +: RA];
    assign rt_idx  = bus.instruction[16 +: RA];
    assign rd_idx  = bus.instruction[11 +: RA];
    assign imm_ext = {{(DW-16){bus.instruction[15]}}, bus.instruction[15:0]};

    // ------------------------------------------------------------------
    // Register file
    // Flop-based rather than RAM because every entry must clear on the
    // asynchronous reset. Entry 0 is never written, so it stays at zero.
    // ------------------------------------------------------------------
    logic [DW-1:0] rf_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_rf
            logic we;
            assign we = bus.regWrite && (bus.writeRegister == RA'(gi)) && (gi != 0);

            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    rf_reg[gi] <= '0;
                end else if (we) begin
                    rf_reg[gi] <= bus.writeData;
                end
            end
        end
    endgenerate

    // Operand read with writeback bypass. Index 0 reads zero even when a
    // write to r0 is presented on the same cycle.
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;

    always_comb begin
        rs_val = rf_reg[rs_idx];
        if (rs_idx == '0) begin
            rs_val = '0;
        end else if (bus.regWrite && (bus.writeRegister == rs_idx)) begin
            rs_val = bus.writeData;
        end

        rt_val = rf_reg[rt_idx];
        if (rt_idx == '0) begin
            rt_val = '0;
        end else if (bus.regWrite && (bus.writeRegister == rt_idx)) begin
            rt_val = bus.writeData;
        end
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic [1:0] ctl_wb;
    logic [2:0] ctl_mem;
    logic [3:0] ctl_calc;
    logic       ctl_mem_read;
    logic       ctl_mem_write;
    logic       ctl_branch;

    always_comb begin
        ctl_wb        = 2'b00;
        ctl_calc      = 4'b0000;
        ctl_mem_read  = 1'b0;
        ctl_mem_write = 1'b0;
        ctl_branch    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctl_wb   = 2'b10;
                ctl_calc = 4'b1100;
            end
            OP_LW: begin
                ctl_wb       = 2'b11;
                ctl_calc     = 4'b0001;
                ctl_mem_read = 1'b1;
            end
            OP_SW: begin
                ctl_calc      = 4'b0001;
                ctl_mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctl_calc   = 4'b0010;
                ctl_branch = 1'b1;
            end
            OP_ADDI: begin
                ctl_wb   = 2'b10;
                ctl_calc = 4'b0001;
            end
            default: ;
        endcase

        ctl_mem                 = 3'b000;
        ctl_mem[MEM_READ_BIT]   = ctl_mem_read;
        ctl_mem[MEM_WRITE_BIT]  = ctl_mem_write;
        ctl_mem[MEM_BRANCH_BIT] = ctl_branch;
    end

    // ------------------------------------------------------------------
    // Execute-stage output registers
    // ------------------------------------------------------------------
    logic          out_valid_reg,  out_valid_next;
    logic [1:0]    wb_reg,         wb_next;
    logic [2:0]    mem_reg,        mem_next;
    logic [3:0]    calc_reg,       calc_next;
    logic [DW-1:0] pc_reg,         pc_next;
    logic [DW-1:0] rd1_reg,        rd1_next;
    logic [DW-1:0] rd2_reg,        rd2_next;
    logic [DW-1:0] imm_reg,        imm_next;
    logic [RA-1:0] wr0_reg,        wr0_next;
    logic [RA-1:0] wr1_reg,        wr1_next;
    logic [SW-1:0] stall_cnt_reg,  stall_cnt_next;

    // The load currently sitting in EX produces its value too late for the
    // instruction now in ID. Because the bubble clears out_valid_reg, the
    // hazard can never hold for two consecutive cycles.
    logic hazard;

    assign hazard = bus.inValid && out_valid_reg && mem_reg[MEM_READ_BIT] &&
                    (wr0_reg != '0) &&
                    ((wr0_reg == rs_idx) || (wr0_reg == rt_idx));

    // Flush overrides the hold: the instruction is discarded anyway, so
    // fetch is free to move on.
    assign bus.inReady = !hazard || bus.flush;

    always_comb begin
        // Default to a bubble.
        out_valid_next = 1'b0;
        wb_next        = '0;
        mem_next       = '0;
        calc_next      = '0;
        pc_next        = '0;
        rd1_next       = '0;
        rd2_next       = '0;
        imm_next       = '0;
        wr0_next       = '0;
        wr1_next       = '0;
        stall_cnt_next = stall_cnt_reg;

        if (bus.flush) begin
            // bubble; a flushed hazard is not a stall
        end else if (hazard) begin
            if (stall_cnt_reg != '1) begin
                stall_cnt_next = stall_cnt_reg + 1'b1;
            end
        end else if (bus.inValid) begin
            out_valid_next = 1'b1;
            wb_next        = ctl_wb;
            mem_next       = ctl_mem;
            calc_next      = ctl_calc;
            pc_next        = bus.programCounterIn;
            rd1_next       = rs_val;
            rd2_next       = rt_val;
            imm_next       = imm_ext;
            wr0_next       = rt_idx;
            wr1_next       = rd_idx;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            out_valid_reg <= 1'b0;
            wb_reg        <= '0;
            mem_reg       <= '0;
            calc_reg      <= '0;
            pc_reg        <= '0;
            rd1_reg       <= '0;
            rd2_reg       <= '0;
            imm_reg       <= '0;
            wr0_reg       <= '0;
            wr1_reg       <= '0;
            stall_cnt_reg <= '0;
        end else begin
            out_valid_reg <= out_valid_next;
            wb_reg        <= wb_next;
            mem_reg       <= mem_next;
            calc_reg      <= calc_next;
            pc_reg        <= pc_next;
            rd1_reg       <= rd1_next;
            rd2_reg       <= rd2_next;
            imm_reg       <= imm_next;
            wr0_reg       <= wr0_next;
            wr1_reg       <= wr1_next;
            stall_cnt_reg <= stall_cnt_next;
        end
    end

    assign bus.outValid           = out_valid_reg;
    assign bus.writeBackControl   = wb_reg;
    assign bus.memAccessControl   = mem_reg;
    assign bus.calculationControl = calc_reg;
    assign bus.programCounterOut  = pc_reg;
    assign bus.readData1          = rd1_reg;
    assign bus.readData2          = rd2_reg;
    assign bus.immediateOperand   = imm_reg;
    assign bus.writeRegister0     = wr0_reg;
    assign bus.writeRegister1     = wr1_reg;
    assign bus.stallCount         = stall_cnt_reg;

endmodule

// File: tb/tb_decode_stage_hazard.sv
// -----------------------------------------------------------------------------
// tb_decode_stage_hazard
//   Scoreboard bench for decode_stage_hazard.
//   Every driven cycle does the following:
//     - Checks inReady against a reference model.
//     - Pushes the expected registered outputs onto a queue.
//     - Pops that entry after the next rising edge and compares it with the
//       DUT outputs.
//   Phases run in this order:
//     - directed cases
//     - constrained-random traffic
//     - an asynchronous reset in the middle of a stall
// -----------------------------------------------------------------------------
module tb_decode_stage_hazard;

    logic clk;
    logic resetN;

    decode_stage_hazard_if #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .STALL_CNT_WIDTH(16)
    ) bus ();

    decode_stage_hazard #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .MEM_READ_BIT(0), .STALL_CNT_WIDTH(16)
    ) dut (
        .clk   (clk),
        .resetN(resetN),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic [3:0]  calc;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  wr0;
        logic [4:0]  wr1;
        logic [15:0] stall;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        m_out;            // model of the EX-stage registers
    logic [31:0] m_rf [32];        // model of the register file
    int          checks_cnt;
    int          errors_cnt;
    int          cyc_cnt;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd);
        logic [4:0] s, t, d;
        s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        logic [4:0] s, t;
        s = rs[4:0]; t = rt[4:0];
        return {op, s, t, imm};
    endfunction

    // Expected control fields per opcode: {wb[1:0], mem[2:0], calc[3:0]}.
    function automatic logic [8:0] ctl_of(input logic [5:0] op);
        case (op)
            6'h00:   return {2'b10, 3'b000, 4'b1100};
            6'h23:   return {2'b11, 3'b001, 4'b0001};
            6'h2B:   return {2'b00, 3'b010, 4'b0001};
            6'h04:   return {2'b00, 3'b100, 4'b0010};
            6'h08:   return {2'b10, 3'b000, 4'b0001};
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx, input logic rw,
                                           input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (rw && wr == idx) return wd;
        return m_rf[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_out = '0;
        exp_q.delete();
    endtask

    task automatic compare_out(input exp_t e);
        check_val("outValid", bus.outValid,           e.valid);
        check_val("wbCtl",    bus.writeBackControl,   e.wb);
        check_val("memCtl",   bus.memAccessControl,   e.mem);
        check_val("calcCtl",  bus.calculationControl, e.calc);
        check_val("pcOut",    bus.programCounterOut,  e.pc);
        check_val("readData1",bus.readData1,          e.rd1);
        check_val("readData2",bus.readData2,          e.rd2);
        check_val("immOp",    bus.immediateOperand,   e.imm);
        check_val("wr0",      bus.writeRegister0,     e.wr0);
        check_val("wr1",      bus.writeRegister1,     e.wr1);
        check_val("stallCnt", bus.stallCount,         e.stall);
    endtask

    // One transaction. Called just after a falling edge and returns just
    // after the next falling edge. rdy returns the model's inReady.
    task automatic run_cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                             input logic fl, input logic rw, input logic [4:0] wr,
                             input logic [31:0] wd, output logic rdy);
        logic [4:0] rs, rt, rd;
        logic       hz;
        logic [8:0] c;
        exp_t       nx;
        exp_t       e;
        bus.inValid          = v;
        bus.instruction      = ins;
        bus.programCounterIn = pc;
        bus.flush            = fl;
        bus.regWrite         = rw;
        bus.writeRegister    = wr;
        bus.writeData        = wd;
        #1;
        rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11];
        hz = v && m_out.valid && m_out.mem[0] && (m_out.wr0 != 5'd0) &&
             ((m_out.wr0 == rs) || (m_out.wr0 == rt));
        rdy = !hz || fl;
        check_val("inReady", bus.inReady, rdy);

        nx       = '0;
        nx.stall = m_out.stall;
        if (fl) begin
            // bubble
        end else if (hz) begin
            if (m_out.stall != 16'hFFFF) nx.stall = m_out.stall + 16'd1;
        end else if (v) begin
            c        = ctl_of(ins[31:26]);
            nx.valid = 1'b1;
            nx.wb    = c[8:7];
            nx.mem   = c[6:4];
            nx.calc  = c[3:0];
            nx.pc    = pc;
            nx.rd1   = m_read(rs, rw, wr, wd);
            nx.rd2   = m_read(rt, rw, wr, wd);
            nx.imm   = {{16{ins[15]}}, ins[15:0]};
            nx.wr0   = rt;
            nx.wr1   = rd;
        end
        exp_q.push_back(nx);
        if (rw && wr != 5'd0) m_rf[wr] = wd;
        m_out = nx;

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        compare_out(e);
        cyc_cnt++;
        $display("cyc %0d v=%0b ins=%08h fl=%0b rw=%0b wr=%0d rdy=%0b -> ov=%0b rd1=%08h rd2=%08h imm=%08h stall=%0d",
                 cyc_cnt, v, ins, fl, rw, wr, bus.inReady, bus.outValid, bus.readData1,
                 bus.readData2, bus.immediateOperand, bus.stallCount);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.inValid = 1'b0; bus.instruction = 32'd0; bus.programCounterIn = 32'd0;
        bus.flush = 1'b0; bus.regWrite = 1'b0; bus.writeRegister = 5'd0; bus.writeData = 32'd0;
    endtask

    task automatic check_reset_state(input string pfx);
        check_val({pfx, "_outValid"}, bus.outValid, 1'b0);
        check_val({pfx, "_ctl"}, {bus.writeBackControl, bus.memAccessControl, bus.calculationControl}, 9'd0);
        check_val({pfx, "_pc"},   bus.programCounterOut, 32'd0);
        check_val({pfx, "_rd1"},  bus.readData1, 32'd0);
        check_val({pfx, "_rd2"},  bus.readData2, 32'd0);
        check_val({pfx, "_imm"},  bus.immediateOperand, 32'd0);
        check_val({pfx, "_wr"},   {bus.writeRegister0, bus.writeRegister1}, 10'd0);
        check_val({pfx, "_stall"},bus.stallCount, 16'd0);
        check_val({pfx, "_inReady"}, bus.inReady, 1'b1);
    endtask

    initial begin
        logic        rdy;
        logic [31:0] cur_ins;
        logic [31:0] cur_pc;
        logic        have_ins;
        logic [15:0] stall_before;

        checks_cnt = 0;
        errors_cnt = 0;
        cyc_cnt    = 0;
        resetN     = 1'b0;
        idle_inputs();
        model_reset();

        repeat (2) @(negedge clk);
        check_reset_state("rst0");
        resetN = 1'b1;

        // Load r1..r7 with known values, with no instruction in flight.
        for (int i = 1; i < 8; i++)
            run_cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 5'(i), 32'h1000_0000 + 32'(i), rdy);

        // Bypass: a write to r5 and a reader of r5 on the same cycle.
        run_cycle(1'b1, r_ins(5, 0, 7), 32'h0000_0104, 1'b0, 1'b1, 5'd5, 32'h0000_1234, rdy);
        check_val("bypass_rd1", bus.readData1, 32'h0000_1234);

        // Immediate sign extension.
        run_cycle(1'b1, i_ins(6'h08, 1, 2, 16'h8000), 32'h108, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
        check_val("imm_neg", bus.immediateOperand, 32'hFFFF_8000);
        run_cycle(1'b1, i_ins(6'h08, 1, 2, 16'h7FFF), 32'h10C, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
        check_val("imm_pos", bus.immediateOperand, 32'h0000_7FFF);

        // Invalid input gives a bubble.
        run_cycle(1'b0, r_ins(1, 2, 3), 32'h110, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
        check_val("invalid_bubble", bus.outValid, 1'b0);

        // Load-use: lw r3 then add rs=r3 -> one stall, then issue with bypass.
        run_cycle(1'b1, i_ins(6'h23, 0, 3, 16'h0004), 32'h114, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
        run_cycle(1'b1, r_ins(3, 5, 8), 32'h118, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
        check_val("lu_hold", rdy, 1'b0);
        check_val("lu_bubble", bus.outValid, 1'b0);
        check_val("lu_stall", bus.stallCount, 16'd1);
        run_cycle(1'b1, r_ins(3, 5, 8), 32'h118, 1'b0, 1'b1, 5'd3, 32'h0000_AAAA, rdy);
        check_val("lu_issue", bus.outValid, 1'b1);
        check_val("lu_rd1", bus.readData1, 32'h0000_AAAA);

        // Flush during a hazard: bubble, fetch not held, stall count unchanged.
        run_cycle(1'b1, i_ins(6'h23, 0, 4, 16'h0008), 32'h11C, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
        run_cycle(1'b1, r_ins(4, 0, 9), 32'h120, 1'b1, 1'b0, 5'd0, 32'd0, rdy);
        check_val("fl_ready", rdy, 1'b1);
        check_val("fl_bubble", bus.outValid, 1'b0);
        check_val("fl_stall", bus.stallCount, 16'd1);

        // Register 0: writes ignored, reads zero, loads to r0 never stall.
        run_cycle(1'b1, r_ins(0, 0, 1), 32'h124, 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, rdy);
        check_val("r0_bypass", bus.readData1, 32'd0);
        run_cycle(1'b1, r_ins(0, 0, 1), 32'h128, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
        check_val("r0_read", bus.readData1, 32'd0);
        run_cycle(1'b1, i_ins(6'h23, 0, 0, 16'h0000), 32'h12C, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
        run_cycle(1'b1, r_ins(0, 0, 2), 32'h130, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
        check_val("r0_nostall", rdy, 1'b1);
        check_val("r0_issue", bus.outValid, 1'b1);

        // Constrained-random traffic over r0..r7, respecting inReady.
        have_ins = 1'b0;
        cur_ins  = 32'd0;
        cur_pc   = 32'h200;
        for (int n = 0; n < 300; n++) begin
            logic       v, fl, rw;
            logic [4:0] wr;
            int         kind;
            if (!have_ins) begin
                kind = int'($urandom_range(0, 5));
                case (kind)
                    0, 1: cur_ins = i_ins(6'h23, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom));
                    2:    cur_ins = i_ins(6'h2B, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom));
                    3:    cur_ins = i_ins(6'h04, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom));
                    4:    cur_ins = i_ins(6'h3F, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 16'($urandom));
                    default: cur_ins = r_ins(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
                endcase
                cur_pc = cur_pc + 32'd4;
            end
            v  = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 9) == 0);
            rw = $urandom_range(0, 1) == 1;
            wr = 5'($urandom_range(0, 7));
            run_cycle(v, cur_ins, cur_pc, fl, rw, wr, $urandom, rdy);
            have_ins = !rdy;
        end

        // Asynchronous reset in the middle of a stall.
        run_cycle(1'b1, i_ins(6'h23, 0, 6, 16'h0010), 32'h300, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
        stall_before = m_out.stall;
        bus.inValid = 1'b1; bus.instruction = r_ins(6, 1, 10); bus.programCounterIn = 32'h304;
        bus.flush = 1'b0; bus.regWrite = 1'b0; bus.writeRegister = 5'd0; bus.writeData = 32'd0;
        #1;
        check_val("mid_hold", bus.inReady, 1'b0);
        check_val("mid_stall_pre", bus.stallCount, stall_before);
        resetN = 1'b0;
        #1;
        check_reset_state("rst_mid");
        model_reset();
        @(posedge clk);
        #1;
        check_reset_state("rst_hold");
        @(negedge clk);
        resetN = 1'b1;
        idle_inputs();
        run_cycle(1'b1, r_ins(6, 1, 10), 32'h304, 1'b0, 1'b0, 5'd0, 32'd0, rdy);
        check_val("post_rst_rd1", bus.readData1, 32'd0);
        check_val("post_rst_stall", bus.stallCount, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
